// File: rtl/i2c_opl3_write_sched_pkg.sv
// Shared types and defaults for the I2C-to-OPL3 register write scheduler.
package opl3_i2c_pkg;

  localparam int unsigned DEF_FIFO_DEPTH  = 16;
  localparam int unsigned DEF_WR_GAP_CLKS = 32;

  typedef struct packed {
    logic       bank;
    logic [7:0] addr;
    logic [7:0] data;
  } opl_wr_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_BANK,
    P_ADDR,
    P_DATA
  } parse_st_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_GAP
  } issue_st_t;

endpackage

// File: rtl/i2c_opl3_write_sched_sync_fifo.sv
// Single-clock FIFO with a registered occupancy level; full/empty derive from the level.
module sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the registered level, so a push at full is refused even with a same-cycle pop.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2c_opl3_write_sched.sv
// Parses I2C writes [bank, addr, data...] into OPL3 register writes, queues them and issues them with a minimum gap.
module i2c_opl3_write_sched
  import opl3_i2c_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned WR_GAP_CLKS = DEF_WR_GAP_CLKS
) (
  input  logic                         clk_10MHz,
  input  logic                         areset_n,
  input  logic                         rx_start,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_stop,
  output logic                         rx_ready,
  output logic                         opl_wr_valid,
  input  logic                         opl_wr_ready,
  output logic                         opl_bank,
  output logic [7:0]                   opl_addr,
  output logic [7:0]                   opl_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  input  logic                         clr_overflow
);

  localparam int unsigned GAP_W = (WR_GAP_CLKS > 1) ? $clog2(WR_GAP_CLKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WR_GAP_CLKS - 1);

  parse_st_t        p_st;
  issue_st_t        i_st;
  logic             bank_r;
  logic [7:0]       addr_r;
  logic [GAP_W-1:0] gap_cnt;
  logic             full;
  logic             empty;
  logic             data_byte;
  logic             push;
  logic             drop;
  logic             pop;
  opl_wr_t          wr_word;
  opl_wr_t          head;

  // A start in the same cycle as a byte wins, so that byte never counts as data.
  assign data_byte = rx_valid && !rx_start && (p_st == P_DATA);
  assign push      = data_byte && !full;
  assign drop      = data_byte && full;
  assign pop       = (i_st == S_IDLE) && !empty;
  assign rx_ready  = !full;
  assign wr_word   = '{bank: bank_r, addr: addr_r, data: rx_data};

  sync_fifo #(
    .WIDTH ($bits(opl_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_10MHz),
    .areset_n (areset_n),
    .push     (push),
    .wr_data  (wr_word),
    .pop      (pop),
    .rd_data  (head),
    .level    (fifo_level),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) begin
      p_st     <= P_IDLE;
      bank_r   <= 1'b0;
      addr_r   <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end

      if (rx_start) begin
        p_st <= P_BANK;
      end else if (rx_stop) begin
        p_st <= P_IDLE;
      end else if (rx_valid) begin
        case (p_st)
          P_BANK: begin
            bank_r <= rx_data[0];
            p_st   <= P_ADDR;
          end
          P_ADDR: begin
            addr_r <= rx_data;
            p_st   <= P_DATA;
          end
          default: p_st <= p_st;
        endcase
      end

      // Address auto-increments on every data byte, dropped or not; bank never follows the wrap.
      if (data_byte) begin
        addr_r <= addr_r + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_10MHz or negedge areset_n) begin
    if (!areset_n) begin
      i_st         <= S_IDLE;
      opl_wr_valid <= 1'b0;
      opl_bank     <= 1'b0;
      opl_addr     <= '0;
      opl_data     <= '0;
      gap_cnt      <= '0;
    end else begin
      case (i_st)
        S_IDLE: begin
          if (!empty) begin
            opl_bank     <= head.bank;
            opl_addr     <= head.addr;
            opl_data     <= head.data;
            opl_wr_valid <= 1'b1;
            i_st         <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (opl_wr_ready) begin
            opl_wr_valid <= 1'b0;
            gap_cnt      <= GAP_LOAD;
            i_st         <= (WR_GAP_CLKS == 1) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            i_st <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: i_st <= S_IDLE;
      endcase
    end
  end

endmodule
